sqrt_req_arbiter: RTL
=====================

// Module: sqrt_req_arbiter
// PURPOSE
//  Shares one pipelined square-root core (one issue/cycle, fixed latency) among NUM_REQ requesters.
//  Round-robin arbitration, registered issue into the core, ID-tag delay line matched to core latency,
//  and routing of each result back to the requester that issued it. Sits between client blocks and the core.
// PARAMETERS
//  NUM_REQ       4   number of requesters (>=2)
//  INPUT_BITS    16  radicand width
//  OUTPUT_BITS   8   root width
//  CORE_LATENCY  9   cycles from core_start to core_valid (OUTPUT_BITS+1 for the standard core)
//  ID_W (localparam) = $clog2(NUM_REQ); CNT_W (localparam) = $clog2(CORE_LATENCY+2)
// PORTS
//  clk            in   1                    clock
//  reset_n        in   1                    asynchronous, active-low reset
//  req_valid      in   NUM_REQ              per-requester request valid
//  req_radicand   in   NUM_REQ*INPUT_BITS   packed radicands, requester i at [i*INPUT_BITS +: INPUT_BITS]
//  req_ready      out  NUM_REQ              one-hot grant; transfer when req_valid[i]&req_ready[i]
//  hold           in   1                    1 = block new grants (in-flight ops complete)
//  rsp_valid      out  NUM_REQ              one-hot result strobe, 1 cycle
//  rsp_root       out  OUTPUT_BITS          result root, valid with rsp_valid
//  core_start     out  1                    issue strobe to core
//  core_radicand  out  INPUT_BITS           radicand to core
//  core_valid     in   1                    core result valid
//  core_root      in   OUTPUT_BITS          core result
//  busy           out  1                    ops in flight or issue pending
//  err_tag        out  1                    sticky: core_valid with no tag, or tag without core_valid
// BEHAVIOUR
//  Reset (async): req_ready=0, rsp_valid=0, rsp_root=0, core_start=0, core_radicand=0, busy=0, err_tag=0,
//   tag pipe cleared, in-flight count 0, RR pointer=0. All in-flight ops dropped; core shares reset.
//  Arbitration: combinational. req_ready = one-hot of first req_valid at or after pointer (wrapping);
//   all-zero when hold=1 or no valid. At most one grant per cycle. On transfer pointer <= grant_id+1 (mod NUM_REQ);
//   pointer unchanged otherwise. Requesters hold valid/radicand stable until transfer; ready never depends on
//   a requester's own valid except via arbitration.
//  Issue: cycle after transfer, core_start=1 and core_radicand=captured radicand (registered); else core_start=0,
//   core_radicand holds last value. Back-to-back issue every cycle sustained.
//  Tag pipe: CORE_LATENCY-deep shift of {vld,id}; entry written with {core_start, issued id} in the cycle core_start
//   is driven; shifts every cycle (no stall). Head aligns with core_valid.
//  Response: cycle after core_valid with head vld=1: rsp_valid = onehot(head id), rsp_root = core_root.
//   rsp_root holds otherwise. No backpressure on rsp; requesters must accept.
//  Latency: transfer edge -> rsp_valid = CORE_LATENCY+2 cycles (11 at defaults).
//  err_tag: set when core_valid != head vld; mismatched core result discarded (no rsp_valid); clears only on reset.
//  busy = core_start | any tag vld | in-flight count!=0; counter +1 on transfer, -1 on rsp; simultaneous -> unchanged.
//   Counter never exceeds CORE_LATENCY+1.
//  hold asserted mid-stream: grants stop same cycle; already-transferred ops issue and return normally.
//  Single requester alone: granted every cycle it is valid (pointer wrap does not skip it).
// STRUCTURE
//  Shared package: sqrt_arb_pkg with ID_W/CNT_W functions and tag struct {vld, id}.
//  One sub-module: rr_arbiter (NUM_REQ, valid vector + advance -> one-hot grant, owns pointer).
//  Tag pipe, issue register, response register inline.
// TESTING (bench uses core model: floor sqrt, CORE_LATENCY=9)
//  req0 radicand 144, others idle -> req_ready[0] same cycle; rsp_valid=4'b0001, rsp_root=12 at +11 cycles.
//  all four valid continuously, radicands 1,4,9,16 -> grants 0,1,2,3,0,...; core_start every cycle; roots 1,2,3,4
//   to matching requester, in order.
//  req1, req3 valid only, pointer after grant 3 -> next grant 1, then 3; never 0/2; no starvation over 100 cycles.
//  hold=1 for 5 cycles during stream -> req_ready=0 throughout, in-flight results still return, busy falls after drain.
//  force core_valid=1 with empty tag pipe -> err_tag=1 sticky, rsp_valid stays 0; cleared only by reset_n.
//  reset_n pulse with 6 ops in flight -> all outputs 0 immediately; no rsp_valid after release until new request.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_arb_pkg
//  Description : Shared widths and the ID-tag record for the square-root
//                request arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package sqrt_arb_pkg;

   // Widest requester ID the tag record can carry (up to 256 requesters).
   localparam int TAG_ID_MAX_W = 8;

   // Requester ID width; a 2-requester arbiter still needs one bit.
   function automatic int id_width(input int num_req);
      return (num_req <= 2) ? 1 : $clog2(num_req);
   endfunction

   // In-flight counter width, sized to hold CORE_LATENCY+1 with headroom.
   function automatic int cnt_width(input int core_latency);
      return $clog2(core_latency + 2);
   endfunction

   // One slot of the tag delay line: valid flag plus issuing requester.
   typedef struct packed {
      logic                    vld;
      logic [TAG_ID_MAX_W-1:0] id;
   } tag_t;

endpackage
`default_nettype wire

// File: rtl/sqrt_req_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant over a valid vector. Owns
//                the priority pointer, which moves past the winner on advance.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            valid_i,
   input  logic                          advance_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic [id_width(NUM_REQ)-1:0]  grant_id_o
);

   localparam int ID_W = id_width(NUM_REQ);

   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;
   logic            hit;

   // First valid at or above the pointer wins; otherwise wrap to the lowest valid.
   always_comb begin
      grant_o    = '0;
      grant_id_o = '0;
      hit        = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!hit && valid_i[i] && (i >= int'(ptr_q))) begin
            hit           = 1'b1;
            grant_o[i]    = 1'b1;
            grant_id_o    = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!hit && valid_i[i]) begin
            hit           = 1'b1;
            grant_o[i]    = 1'b1;
            grant_id_o    = ID_W'(i);
         end
      end
   end

   // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         if (grant_id_o == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_id_o + ID_W'(1);
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sqrt_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_req_arbiter
//  Description : Shares one fixed-latency pipelined square-root core among
//                NUM_REQ requesters: round-robin grant, registered issue,
//                ID-tag delay line and routing of results back to the issuer.
//  Revision    : 1.0  initial release
// ============================================================================
module sqrt_req_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int INPUT_BITS   = 16,
   parameter int OUTPUT_BITS  = 8,
   parameter int CORE_LATENCY = 9
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*INPUT_BITS-1:0] req_radicand_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          hold_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic [OUTPUT_BITS-1:0]        rsp_root_o,
   output logic                          core_start_o,
   output logic [INPUT_BITS-1:0]         core_radicand_o,
   input  logic                          core_valid_i,
   input  logic [OUTPUT_BITS-1:0]        core_root_i,
   output logic                          busy_o,
   output logic                          err_tag_o
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = cnt_width(CORE_LATENCY);

   // Arbitration
   logic [NUM_REQ-1:0]    valid_masked;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       grant_id;
   logic                  xfer;
   logic [INPUT_BITS-1:0] radicand_sel;

   // Issue register
   logic                  start_q;
   logic [INPUT_BITS-1:0] radicand_q;
   logic [ID_W-1:0]       issue_id_q;

   // Tag delay line
   tag_t                  tag_q [CORE_LATENCY];
   tag_t                  tag_head;
   logic                  tag_any;

   // Response / status
   logic [NUM_REQ-1:0]     rsp_onehot;
   logic [NUM_REQ-1:0]     rsp_valid_q;
   logic [OUTPUT_BITS-1:0] rsp_root_q;
   logic                   err_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;

   // hold and reset both suppress grants; ready must read 0 while in reset.
   assign valid_masked = req_valid_i & {NUM_REQ{~hold_i & reset_n}};

   rr_arbiter #(
      .NUM_REQ    (NUM_REQ)
   ) u_rr_arbiter (
      .clk        (clk),
      .reset_n    (reset_n),
      .valid_i    (valid_masked),
      .advance_i  (xfer),
      .grant_o    (grant),
      .grant_id_o (grant_id)
   );

   assign req_ready_o = grant;
   assign xfer        = |(req_valid_i & grant);

   // Select the granted requester's radicand (grant is one-hot).
   always_comb begin
      radicand_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            radicand_sel = radicand_sel | req_radicand_i[i*INPUT_BITS +: INPUT_BITS];
         end
      end
   end

   // Issue stage: one-cycle start strobe, radicand holds its last value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_q    <= 1'b0;
         radicand_q <= '0;
         issue_id_q <= '0;
      end else begin
         start_q <= xfer;
         if (xfer) begin
            radicand_q <= radicand_sel;
            issue_id_q <= grant_id;
         end
      end
   end

   assign core_start_o    = start_q;
   assign core_radicand_o = radicand_q;

   // Tag delay line: free-running shift, head lines up with core_valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CORE_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= '{vld: start_q, id: TAG_ID_MAX_W'(issue_id_q)};
         for (int i = 1; i < CORE_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign tag_head = tag_q[CORE_LATENCY-1];

   // Any live tag anywhere in the line, plus one-hot decode of the head ID.
   always_comb begin
      tag_any    = 1'b0;
      rsp_onehot = '0;
      for (int i = 0; i < CORE_LATENCY; i++) begin
         tag_any = tag_any | tag_q[i].vld;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_onehot[i] = (tag_head.id == TAG_ID_MAX_W'(i));
      end
   end

   // Response register; a core result without a matching tag is dropped and flagged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= '0;
         rsp_root_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= '0;
         if (core_valid_i && tag_head.vld) begin
            rsp_valid_q <= rsp_onehot;
            rsp_root_q  <= core_root_i;
         end
         if (core_valid_i != tag_head.vld) begin
            err_q <= 1'b1;
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_root_o  = rsp_root_q;
   assign err_tag_o   = err_q;

   // In-flight count: up on transfer, down when the op's tag leaves the line.
   always_comb begin
      cnt_d = cnt_q;
      case ({xfer, tag_head.vld})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // In-flight counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = start_q | tag_any | (cnt_q != '0);

endmodule
`default_nettype wire
